// File: rtl/tsc_fifo_sync_v3.sv
// ---------------------------------------------------------------------------
// tsc_fifo_sync_v3
// Single-clock FIFO over an inferred simple-dual-port RAM. Pointers,
// occupancy counter and status flags are internal. Data width and depth are
// parameters.
//
// Build option:
//   TSC_FIFO_FWFT_EN  defined   -> first-word-fall-through output stage
//                     undefined -> standard mode (qv pulses one cycle per pop)
//
// Parameters:
//   DW         data width, 1..72
//   AW         address width, depth = 2**AW, 2..14
//   AFULL_TH   almost_full  when count >= AFULL_TH
//   AEMPTY_TH  almost_empty when count <= AEMPTY_TH
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   we / dw       in   write request / write data
//   re            in   read (pop) request
//   qr            out  read data
//   qv            out  qr holds a valid word
//   full / empty  out  occupancy flags (registered)
//   almost_full   out  count >= AFULL_TH
//   almost_empty  out  count <= AEMPTY_TH
//   count         out  words held, output register included
//   overflow      out  one-cycle pulse after a refused write
//   underflow     out  one-cycle pulse after a refused read
// ---------------------------------------------------------------------------
module tsc_fifo_sync_v3 #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 10,
  parameter int unsigned AFULL_TH  = (1 << AW) - 4,
  parameter int unsigned AEMPTY_TH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] dw,
  input  logic          re,
  output logic [DW-1:0] qr,
  output logic          qv,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  // Storage and RAM read port
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_ram_q;

  // Pointers, occupancy, flags
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_afull;
  logic          r_aempty;
  logic          r_ovf;
  logic          r_unf;

  // Output stage
  logic          r_pend;   // r_ram_q holds a word not yet moved to qr
  logic          r_qv;
  logic [DW-1:0] r_qr;

`ifdef TSC_FIFO_FWFT_EN
  logic [CW-1:0] r_ram_cnt;  // words still in RAM, not yet prefetched
  logic [CW-1:0] w_ram_cnt_nxt;
`endif

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_issue;
  logic          w_xfer;
  logic          w_qv_nxt;
  logic          w_pend_nxt;
  logic          w_empty_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Acceptance, RAM read issue and output-stage handshake
  always_comb begin
    w_wr_acc    = we && !r_full;
    w_rd_acc    = 1'b0;
    w_issue     = 1'b0;
    w_xfer      = 1'b0;
    w_qv_nxt    = 1'b0;
`ifdef TSC_FIFO_FWFT_EN
    w_rd_acc    = re && r_qv;
    // Prefetch unless both the RAM port word and qr are occupied and stay so
    w_issue     = (r_ram_cnt != '0) && !(r_qv && r_pend && !w_rd_acc);
    w_xfer      = r_pend && (!r_qv || w_rd_acc);
    w_qv_nxt    = w_xfer || (r_qv && !w_rd_acc);
`else
    w_rd_acc    = re && !r_empty;
    w_issue     = w_rd_acc;
    w_xfer      = r_pend;
    w_qv_nxt    = r_pend;
`endif
    w_pend_nxt  = w_issue || (r_pend && !w_xfer);
  end

  // Occupancy counter: up/down, cannot leave 0..DEPTH since acceptance is gated
  always_comb begin
    w_cnt_nxt = r_count;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_count + CW'(1);
      2'b01:   w_cnt_nxt = r_count - CW'(1);
      default: w_cnt_nxt = r_count;
    endcase
`ifdef TSC_FIFO_FWFT_EN
    w_ram_cnt_nxt = r_ram_cnt;
    unique case ({w_wr_acc, w_issue})
      2'b10:   w_ram_cnt_nxt = r_ram_cnt + CW'(1);
      2'b01:   w_ram_cnt_nxt = r_ram_cnt - CW'(1);
      default: w_ram_cnt_nxt = r_ram_cnt;
    endcase
    // Nothing readable until a word sits in the output register
    w_empty_nxt = !w_qv_nxt;
`else
    w_empty_nxt = (w_cnt_nxt == '0);
`endif
  end

  // RAM: write port plus synchronous read port, contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= dw;
    end
    if (w_issue) begin
      r_ram_q <= r_mem[r_rptr];
    end
  end

  // Control, flags and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_pend    <= 1'b0;
      r_qv      <= 1'b0;
      r_qr      <= '0;
`ifdef TSC_FIFO_FWFT_EN
      r_ram_cnt <= '0;
`endif
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_issue) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count  <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == CW'(DEPTH));
      r_empty  <= w_empty_nxt;
      r_afull  <= (w_cnt_nxt >= CW'(AFULL_TH));
      r_aempty <= (w_cnt_nxt <= CW'(AEMPTY_TH));
      // Refusals judged on the flags seen at this edge, before any pop
      r_ovf    <= we && r_full;
      r_unf    <= re && r_empty;
      r_pend   <= w_pend_nxt;
      r_qv     <= w_qv_nxt;
      if (w_xfer) begin
        r_qr <= r_ram_q;
      end
`ifdef TSC_FIFO_FWFT_EN
      r_ram_cnt <= w_ram_cnt_nxt;
`endif
    end
  end

  assign qr           = r_qr;
  assign qv           = r_qv;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    r_count <= CW'(DEPTH));
  a_full_not_empty: assert property (@(posedge clk) disable iff (rst)
    !(r_full && r_empty));
`endif

endmodule
